// File: rtl/tail_light_pkg.sv
// Shared types for the tail-light monitor: lamp patterns, decoded modes, error codes and FSM states.
// Helper functions map states to modes, expected lamp patterns and successor states.
package tail_light_pkg;

  localparam logic [2:0] LAMP_OFF = 3'b000;
  localparam logic [2:0] L_1      = 3'b100;
  localparam logic [2:0] L_2      = 3'b110;
  localparam logic [2:0] L_3      = 3'b111;
  localparam logic [2:0] R_1      = 3'b001;
  localparam logic [2:0] R_2      = 3'b011;
  localparam logic [2:0] R_3      = 3'b111;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_HAZ   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_STALL   = 2'd2,
    ERR_GLITCH  = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, H1, H2, H3
  } state_e;

  function automatic mode_e state_mode(input state_e s);
    case (s)
      L1, L2, L3: state_mode = MODE_LEFT;
      R1, R2, R3: state_mode = MODE_RIGHT;
      H1, H2, H3: state_mode = MODE_HAZ;
      default:    state_mode = MODE_IDLE;
    endcase
  endfunction

  // Lamp pattern {tl,tr} that is on the bus while the FSM sits in state s.
  function automatic logic [5:0] state_pattern(input state_e s);
    case (s)
      L1:      state_pattern = {L_1, LAMP_OFF};
      L2:      state_pattern = {L_2, LAMP_OFF};
      L3:      state_pattern = {L_3, LAMP_OFF};
      R1:      state_pattern = {LAMP_OFF, R_1};
      R2:      state_pattern = {LAMP_OFF, R_2};
      R3:      state_pattern = {LAMP_OFF, R_3};
      H1:      state_pattern = {L_1, R_1};
      H2:      state_pattern = {L_2, R_2};
      H3:      state_pattern = {L_3, R_3};
      default: state_pattern = {LAMP_OFF, LAMP_OFF};
    endcase
  endfunction

  function automatic state_e state_succ(input state_e s);
    case (s)
      L1:      state_succ = L2;
      L2:      state_succ = L3;
      R1:      state_succ = R2;
      R2:      state_succ = R3;
      H1:      state_succ = H2;
      H2:      state_succ = H3;
      default: state_succ = IDLE;
    endcase
  endfunction

  // Entry decode from IDLE; IDLE result for a non-dark pattern means illegal.
  function automatic state_e decode_entry(input logic [5:0] pat);
    if (pat == {L_1, LAMP_OFF})      decode_entry = L1;
    else if (pat == {LAMP_OFF, R_1}) decode_entry = R1;
    else if (pat == {L_1, R_1})      decode_entry = H1;
    else                             decode_entry = IDLE;
  endfunction

endpackage

// File: rtl/tail_light_monitor_sat_counter.sv
// Saturating up-counter, holds at all-ones. Latency 1 clock; no backpressure.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clear)                      value_d = '0;
    else if (inc && value_q != '1)  value_d = value_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/tail_light_monitor.sv
// Tail-light lamp-bus checker: decodes and validates ramps, counts cycles, flags errors; outputs registered (1 clock), no backpressure.
// Optional TAIL_LIGHT_GLITCH_CHECK_EN flags lamp-bus changes between step strobes.
module tail_light_monitor
  import tail_light_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int STALL_MAX = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic [2:0]       tl,
  input  logic [2:0]       tr,
  input  logic             err_clr,
  output logic [1:0]       mode,
  output logic             cycle_done,
  output logic [1:0]       done_mode,
  output logic             err_pulse,
  output logic [1:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] haz_cnt
);

  localparam int SW = $clog2(STALL_MAX + 1);

  state_e        state_q, state_d;
  logic [SW-1:0] stall_q, stall_d;
  mode_e         mode_q, mode_d;
  logic          cycle_done_q, cycle_done_d;
  mode_e         done_mode_q, done_mode_d;
  logic          err_pulse_q, err_pulse_d;
  err_e          err_code_q, err_code_d;
  logic          err_sticky_q, err_sticky_d;

  logic          new_err;
  err_e          new_code;
  logic [5:0]    sample;

`ifdef TAIL_LIGHT_GLITCH_CHECK_EN
  logic [5:0]    lamp_q, lamp_d;
`endif

  always_comb begin
    sample       = {tl, tr};
    state_d      = state_q;
    stall_d      = stall_q;
    cycle_done_d = 1'b0;
    done_mode_d  = MODE_IDLE;
    new_err      = 1'b0;
    new_code     = ERR_NONE;

    if (step) begin
      stall_d = '0;
      if (state_q == IDLE) begin
        state_d = decode_entry(sample);
        if (state_d == IDLE && sample != 6'b0) begin
          new_err  = 1'b1;
          new_code = ERR_ILLEGAL;
        end
      end else if (sample == 6'b0) begin
        // Dark bus closes a cycle from X3, otherwise it is a silent abort.
        state_d = IDLE;
        if (state_q inside {L3, R3, H3}) begin
          cycle_done_d = 1'b1;
          done_mode_d  = state_mode(state_q);
        end
      end else if (!(state_q inside {L3, R3, H3}) &&
                   sample == state_pattern(state_succ(state_q))) begin
        state_d = state_succ(state_q);
      end else begin
        // Mismatch: report it, then treat the sample as a fresh entry.
        state_d  = decode_entry(sample);
        new_err  = 1'b1;
        new_code = ERR_ILLEGAL;
      end
    end else if (state_q != IDLE) begin
      if (stall_q == SW'(STALL_MAX - 1)) begin
        state_d  = IDLE;
        stall_d  = '0;
        new_err  = 1'b1;
        new_code = ERR_STALL;
      end else begin
        stall_d = stall_q + SW'(1);
      end
    end else begin
      stall_d = '0;
    end

`ifdef TAIL_LIGHT_GLITCH_CHECK_EN
    lamp_d = sample;
    if (!step && !new_err && sample != lamp_q) begin
      new_err  = 1'b1;
      new_code = ERR_GLITCH;
    end
`endif

    mode_d       = state_mode(state_d);
    err_pulse_d  = new_err;
    err_code_d   = err_code_q;
    err_sticky_d = err_sticky_q;
    if (new_err) begin
      err_code_d   = new_code;
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_code_d   = ERR_NONE;
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      stall_q      <= '0;
      mode_q       <= MODE_IDLE;
      cycle_done_q <= 1'b0;
      done_mode_q  <= MODE_IDLE;
      err_pulse_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stall_q      <= stall_d;
      mode_q       <= mode_d;
      cycle_done_q <= cycle_done_d;
      done_mode_q  <= done_mode_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
      err_sticky_q <= err_sticky_d;
    end
  end

`ifdef TAIL_LIGHT_GLITCH_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lamp_q <= '0;
    else        lamp_q <= lamp_d;
  end
`endif

  sat_counter #(.W(CNT_W)) u_left_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cycle_done_d && done_mode_d == MODE_LEFT),
    .clear (1'b0),
    .value (left_cnt)
  );

  sat_counter #(.W(CNT_W)) u_right_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cycle_done_d && done_mode_d == MODE_RIGHT),
    .clear (1'b0),
    .value (right_cnt)
  );

  sat_counter #(.W(CNT_W)) u_haz_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cycle_done_d && done_mode_d == MODE_HAZ),
    .clear (1'b0),
    .value (haz_cnt)
  );

  assign mode       = mode_q;
  assign cycle_done = cycle_done_q;
  assign done_mode  = done_mode_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_tail_light_monitor.sv
// Directed bench for tail_light_monitor with hand-computed expectations at each step.
module tb_tail_light_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step = 1'b0;
  logic [2:0] tl = 3'b000;
  logic [2:0] tr = 3'b000;
  logic       err_clr = 1'b0;
  logic [1:0] mode;
  logic       cycle_done;
  logic [1:0] done_mode;
  logic       err_pulse;
  logic [1:0] err_code;
  logic       err_sticky;
  logic [7:0] left_cnt;
  logic [7:0] right_cnt;
  logic [7:0] haz_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  tail_light_monitor #(.CNT_W(8), .STALL_MAX(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .tl         (tl),
    .tr         (tr),
    .err_clr    (err_clr),
    .mode       (mode),
    .cycle_done (cycle_done),
    .done_mode  (done_mode),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .left_cnt   (left_cnt),
    .right_cnt  (right_cnt),
    .haz_cnt    (haz_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic [2:0] l, input logic [2:0] r);
    @(negedge clk);
    step = 1'b1;
    tl   = l;
    tr   = r;
    @(posedge clk);
    #1;
    step = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step  = 1'b0;
    tl    = 3'b000;
    tr    = 3'b000;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic left_cycle();
    do_step(3'b100, 3'b000);
    do_step(3'b110, 3'b000);
    do_step(3'b111, 3'b000);
    do_step(3'b000, 3'b000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk("reset_mode", mode, 0);
    chk("reset_err_code", err_code, 0);
    chk("reset_sticky", err_sticky, 0);
    chk("reset_cycle_done", cycle_done, 0);
    chk("reset_left_cnt", left_cnt, 0);

    // Left cycle
    do_step(3'b100, 3'b000);
    chk("left_l1_mode", mode, 1);
    chk("left_l1_done", cycle_done, 0);
    do_step(3'b110, 3'b000);
    chk("left_l2_mode", mode, 1);
    do_step(3'b111, 3'b000);
    chk("left_l3_mode", mode, 1);
    do_step(3'b000, 3'b000);
    chk("left_done", cycle_done, 1);
    chk("left_done_mode", done_mode, 1);
    chk("left_cnt_1", left_cnt, 1);
    chk("left_end_mode", mode, 0);
    @(posedge clk); #1;
    chk("left_done_pulse_end", cycle_done, 0);

    for (int i = 0; i < 255; i++) left_cycle();
    chk("left_cnt_sat", left_cnt, 255);
    chk("left_sat_sticky", err_sticky, 0);

    // Right then hazard
    do_step(3'b000, 3'b001);
    chk("right_r1_mode", mode, 2);
    do_step(3'b000, 3'b011);
    do_step(3'b000, 3'b111);
    chk("right_r3_mode", mode, 2);
    do_step(3'b000, 3'b000);
    chk("right_done", cycle_done, 1);
    chk("right_done_mode", done_mode, 2);
    chk("right_cnt_1", right_cnt, 1);
    do_step(3'b100, 3'b001);
    chk("haz_h1_mode", mode, 3);
    do_step(3'b110, 3'b011);
    do_step(3'b111, 3'b111);
    do_step(3'b000, 3'b000);
    chk("haz_done", cycle_done, 1);
    chk("haz_done_mode", done_mode, 3);
    chk("haz_cnt_1", haz_cnt, 1);
    chk("rh_sticky", err_sticky, 0);
    chk("rh_left_cnt_hold", left_cnt, 255);

    // Reset mid-sequence
    do_step(3'b100, 3'b000);
    chk("mid_l1_mode", mode, 1);
    do_reset();
    chk("mid_reset_mode", mode, 0);
    chk("mid_reset_left_cnt", left_cnt, 0);
    chk("mid_reset_haz_cnt", haz_cnt, 0);

    // Illegal mismatch in R1 resyncs into L1
    do_step(3'b000, 3'b001);
    chk("resync_r1_mode", mode, 2);
    do_step(3'b100, 3'b000);
    chk("resync_pulse", err_pulse, 1);
    chk("resync_code", err_code, 1);
    chk("resync_sticky", err_sticky, 1);
    chk("resync_mode", mode, 1);
    do_step(3'b110, 3'b000);
    chk("resync_pulse_end", err_pulse, 0);
    do_step(3'b111, 3'b000);
    do_step(3'b000, 3'b000);
    chk("resync_done", cycle_done, 1);
    chk("resync_left_cnt", left_cnt, 1);
    do_clr();
    chk("clr_sticky", err_sticky, 0);
    chk("clr_code", err_code, 0);

    // Abort hazard
    do_step(3'b100, 3'b001);
    chk("abort_h1_mode", mode, 3);
    do_step(3'b000, 3'b000);
    chk("abort_mode", mode, 0);
    chk("abort_done", cycle_done, 0);
    chk("abort_pulse", err_pulse, 0);
    chk("abort_haz_cnt", haz_cnt, 0);

    // Illegal pattern from IDLE
    do_step(3'b010, 3'b000);
    chk("idle_illegal_pulse", err_pulse, 1);
    chk("idle_illegal_code", err_code, 1);
    chk("idle_illegal_mode", mode, 0);
    do_clr();
    chk("idle_clr_sticky", err_sticky, 0);

    // Stall watchdog
    do_step(3'b100, 3'b000);
    chk("stall_l1_mode", mode, 1);
    repeat (999) @(posedge clk);
    #1;
    chk("stall_999_pulse", err_pulse, 0);
    chk("stall_999_mode", mode, 1);
    @(posedge clk); #1;
    chk("stall_pulse", err_pulse, 1);
    chk("stall_code", err_code, 2);
    chk("stall_sticky", err_sticky, 1);
    chk("stall_mode", mode, 0);
    do_clr();
    chk("stall_clr_sticky", err_sticky, 0);
    chk("stall_clr_code", err_code, 0);

    // err_clr coinciding with a new error: error wins
    @(negedge clk);
    err_clr = 1'b1;
    step = 1'b1;
    tl = 3'b010;
    tr = 3'b000;
    @(posedge clk); #1;
    err_clr = 1'b0;
    step = 1'b0;
    chk("clr_vs_err_sticky", err_sticky, 1);
    chk("clr_vs_err_code", err_code, 1);
    do_clr();
    chk("clr2_sticky", err_sticky, 0);

    // Lamp change between strobes while idle
    @(negedge clk);
    tl = 3'b100;
    tr = 3'b000;
    @(posedge clk); #1;
`ifdef TAIL_LIGHT_GLITCH_CHECK_EN
    chk("glitch_pulse", err_pulse, 1);
    chk("glitch_code", err_code, 3);
    chk("glitch_sticky", err_sticky, 1);
`else
    chk("glitch_pulse", err_pulse, 0);
    chk("glitch_code", err_code, 0);
    chk("glitch_sticky", err_sticky, 0);
`endif
    chk("glitch_mode", mode, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
